// File: rtl/msrh_pkg.sv
// Shared constants, types and pointer helper for the commit-side physical register free list.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package msrh_pkg;

  localparam int DISP_SIZE  = 4;
  localparam int RNID_SIZE  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int FL_SIZE    = RNID_SIZE - ARCH_REGS;
  localparam int RNID_W     = $clog2(RNID_SIZE);
  localparam int FL_IDX_W   = $clog2(FL_SIZE);
  localparam int FL_CNT_W   = $clog2(FL_SIZE) + 1;
  localparam int DISP_CNT_W = $clog2(DISP_SIZE + 1);
  localparam int DISP_IDX_W = $clog2(DISP_SIZE);

  // One compacted push lane: valid flag plus the rnid being returned
  typedef struct packed {
    logic              valid;
    logic [RNID_W-1:0] rnid;
  } freelist_push_t;

  // Circular pointer advance; FL_SIZE need not be a power of two, so wrap by
  // compare-and-subtract (n never exceeds DISP_SIZE <= FL_SIZE, one subtract suffices)
  function automatic logic [FL_IDX_W-1:0] fl_ptr_add(input logic [FL_IDX_W-1:0]   ptr,
                                                     input logic [DISP_CNT_W-1:0] n);
    logic [FL_CNT_W:0] sum;
    sum = (FL_CNT_W+1)'(ptr) + (FL_CNT_W+1)'(n);
    if (sum >= (FL_CNT_W+1)'(FL_SIZE)) begin
      sum = sum - (FL_CNT_W+1)'(FL_SIZE);
    end
    return sum[FL_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/msrh_freelist_pack.sv
// Compacts DISP_SIZE sparse lanes into ascending packed entries; also reports each lane's rank.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the packed result is consumed.
module msrh_freelist_pack
  import msrh_pkg::*;
(
  input  logic [DISP_SIZE-1:0]  i_valid,
  input  logic [RNID_W-1:0]     i_rnid [DISP_SIZE],
  output freelist_push_t        o_entry [DISP_SIZE],
  output logic [DISP_CNT_W-1:0] o_rank [DISP_SIZE],
  output logic [DISP_CNT_W-1:0] o_num
);

  logic [DISP_CNT_W-1:0] w_cnt;

  // Running count of valid lanes below each lane gives both rank and packed slot
  always_comb begin
    w_cnt = '0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      o_entry[d] = '0;
      o_rank[d]  = '0;
    end
    for (int d = 0; d < DISP_SIZE; d++) begin
      o_rank[d] = w_cnt;
      if (i_valid[d]) begin
        o_entry[w_cnt[DISP_IDX_W-1:0]] = '{valid: 1'b1, rnid: i_rnid[d]};
        w_cnt = w_cnt + DISP_CNT_W'(1);
      end
    end
    o_num = w_cnt;
  end

endmodule

// File: rtl/msrh_cmt_freelist.sv
// Physical register free list fed by the commit rename-update bus; hands fresh rnids to rename.
// Latency: pops read head combinationally; pushed rnids become poppable the next cycle.
// Backpressure: o_alloc_ready drops below DISP_SIZE free; overflowing pushes are dropped. Option: MSRH_FREELIST_DUP_CHECK_EN.
module msrh_cmt_freelist
  import msrh_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_cmt_commit,
  input  logic [DISP_SIZE-1:0] i_cmt_rnid_valid,
  input  logic [RNID_W-1:0]    i_cmt_old_rnid [DISP_SIZE],
  input  logic [RNID_W-1:0]    i_cmt_rd_rnid [DISP_SIZE],
  input  logic [DISP_SIZE-1:0] i_cmt_dead_id,
  input  logic                 i_cmt_all_dead,
  input  logic [DISP_SIZE-1:0] i_alloc_req,
  output logic                 o_alloc_ready,
  output logic [RNID_W-1:0]    o_alloc_rnid [DISP_SIZE],
  output logic [FL_CNT_W-1:0]  o_free_count,
  output logic                 o_dup_err
);

  logic [RNID_W-1:0]     r_entry [FL_SIZE];
  logic [FL_IDX_W-1:0]   r_head;
  logic [FL_IDX_W-1:0]   r_tail;
  logic [FL_CNT_W-1:0]   r_count;

  logic [DISP_SIZE-1:0]  w_push_vld;
  logic [RNID_W-1:0]     w_push_rnid [DISP_SIZE];
  freelist_push_t        w_push_ent [DISP_SIZE];
  logic [DISP_CNT_W-1:0] w_push_rank_unused [DISP_SIZE];
  logic [DISP_CNT_W-1:0] w_npush_req;
  logic                  w_push_ok;
  logic [DISP_CNT_W-1:0] w_npush;

  logic [RNID_W-1:0]     w_pop_tag [DISP_SIZE];
  freelist_push_t        w_pop_slot_unused [DISP_SIZE];
  logic [DISP_CNT_W-1:0] w_pop_rank [DISP_SIZE];
  logic [DISP_CNT_W-1:0] w_npop_req;
  logic [DISP_CNT_W-1:0] w_npop;

  // Dead slots return their fresh mapping, live slots return the displaced one
  always_comb begin
    for (int d = 0; d < DISP_SIZE; d++) begin
      w_push_vld[d]  = i_cmt_commit & i_cmt_rnid_valid[d];
      w_push_rnid[d] = (i_cmt_dead_id[d] | i_cmt_all_dead) ? i_cmt_rd_rnid[d] : i_cmt_old_rnid[d];
      w_pop_tag[d]   = RNID_W'(d);
    end
  end

  msrh_freelist_pack u_push_pack (
    .i_valid (w_push_vld),
    .i_rnid  (w_push_rnid),
    .o_entry (w_push_ent),
    .o_rank  (w_push_rank_unused),
    .o_num   (w_npush_req)
  );

  // Same compaction on the request vector: a lane's rank is its offset from head
  msrh_freelist_pack u_pop_pack (
    .i_valid (i_alloc_req),
    .i_rnid  (w_pop_tag),
    .o_entry (w_pop_slot_unused),
    .o_rank  (w_pop_rank),
    .o_num   (w_npop_req)
  );

  assign o_alloc_ready = (r_count >= FL_CNT_W'(DISP_SIZE));
  assign o_free_count  = r_count;
  assign w_push_ok     = ((FL_CNT_W+1)'(r_count) + (FL_CNT_W+1)'(w_npush_req)) <= (FL_CNT_W+1)'(FL_SIZE);
  assign w_npush       = w_push_ok ? w_npush_req : '0;
  assign w_npop        = o_alloc_ready ? w_npop_req : '0;

  // Each lane reads the entry rank positions past head; idle lanes alias a live entry
  always_comb begin
    for (int d = 0; d < DISP_SIZE; d++) begin
      o_alloc_rnid[d] = r_entry[fl_ptr_add(r_head, w_pop_rank[d])];
    end
  end

  // Pointer and occupancy update; push and pop may land in the same cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= FL_CNT_W'(FL_SIZE);
    end else begin
      r_head  <= fl_ptr_add(r_head, w_npop);
      r_tail  <= fl_ptr_add(r_tail, w_npush);
      r_count <= r_count + FL_CNT_W'(w_npush) - FL_CNT_W'(w_npop);
    end
  end

  // Write compacted freed rnids at tail onwards; reset image holds every non-arch rnid
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < FL_SIZE; k++) begin
        r_entry[k] <= RNID_W'(ARCH_REGS + k);
      end
    end else if (w_push_ok) begin
      for (int k = 0; k < DISP_SIZE; k++) begin
        if (w_push_ent[k].valid) begin
          r_entry[fl_ptr_add(r_tail, DISP_CNT_W'(k))] <= w_push_ent[k].rnid;
        end
      end
    end
  end

`ifdef MSRH_FREELIST_DUP_CHECK_EN
  logic [RNID_SIZE-1:0] r_in_list;
  logic                 r_dup_err;
  logic                 w_dup_hit;

  // A freed rnid already in the list, or repeated within one group, is a double free
  always_comb begin
    w_dup_hit = 1'b0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      if (w_push_vld[d]) begin
        if (r_in_list[w_push_rnid[d]]) begin
          w_dup_hit = 1'b1;
        end
        for (int e = 0; e < d; e++) begin
          if (w_push_vld[e] && (w_push_rnid[e] == w_push_rnid[d])) begin
            w_dup_hit = 1'b1;
          end
        end
      end
    end
  end

  // Track list membership and latch the sticky double-free flag
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_in_list <= {{FL_SIZE{1'b1}}, {ARCH_REGS{1'b0}}};
      r_dup_err <= 1'b0;
    end else begin
      for (int d = 0; d < DISP_SIZE; d++) begin
        if (o_alloc_ready && i_alloc_req[d]) begin
          r_in_list[o_alloc_rnid[d]] <= 1'b0;
        end
      end
      if (w_push_ok) begin
        for (int d = 0; d < DISP_SIZE; d++) begin
          if (w_push_vld[d]) begin
            r_in_list[w_push_rnid[d]] <= 1'b1;
          end
        end
      end
      if (w_dup_hit) begin
        r_dup_err <= 1'b1;
      end
    end
  end

  assign o_dup_err = r_dup_err;
`else
  assign o_dup_err = 1'b0;
`endif

  a_alloc_only_when_ready: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (|i_alloc_req) |-> o_alloc_ready)
    else $error("rename requested rnids while the free list was not ready");

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    w_push_ok)
    else $error("commit returned more rnids than the free list can hold");

endmodule

// File: tb/tb_msrh_cmt_freelist.sv
module tb_msrh_cmt_freelist;
  import msrh_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 commit;
  logic [DISP_SIZE-1:0] vld;
  logic [RNID_W-1:0]    old_r [DISP_SIZE];
  logic [RNID_W-1:0]    rd_r [DISP_SIZE];
  logic [DISP_SIZE-1:0] dead;
  logic                 all_dead;
  logic [DISP_SIZE-1:0] req;
  logic                 ready;
  logic [RNID_W-1:0]    arnid [DISP_SIZE];
  logic [FL_CNT_W-1:0]  fcount;
  logic                 dup_err;

`ifdef MSRH_FREELIST_DUP_CHECK_EN
  localparam int DUP_EXP = 1;
`else
  localparam int DUP_EXP = 0;
`endif

  always #5 clk = ~clk;

  msrh_cmt_freelist dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_cmt_commit     (commit),
    .i_cmt_rnid_valid (vld),
    .i_cmt_old_rnid   (old_r),
    .i_cmt_rd_rnid    (rd_r),
    .i_cmt_dead_id    (dead),
    .i_cmt_all_dead   (all_dead),
    .i_alloc_req      (req),
    .o_alloc_ready    (ready),
    .o_alloc_rnid     (arnid),
    .o_free_count     (fcount),
    .o_dup_err        (dup_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int q[$];                 // free-list contents, front = next rnid handed out
  bit mapped [RNID_SIZE];   // rnids currently owned by the machine (legal to free)
  bit exp_dup;
  bit chk_en = 1'b0;
  int cmp_k;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = ARCH_REGS; i < RNID_SIZE; i++) q.push_back(i);
    for (int i = 0; i < RNID_SIZE; i++) mapped[i] = (i < ARCH_REGS);
    exp_dup = 1'b0;
  endtask

  // Apply the rules for the edge that just happened, using the inputs held across it
  task automatic model_update();
    int vals[$];
    int pre;
    int v;
    pre = q.size();
    for (int d = 0; d < DISP_SIZE; d++)
      if (commit && vld[d]) vals.push_back((dead[d] || all_dead) ? int'(rd_r[d]) : int'(old_r[d]));
`ifdef MSRH_FREELIST_DUP_CHECK_EN
    for (int i = 0; i < vals.size(); i++) begin
      foreach (q[j]) if (q[j] == vals[i]) exp_dup = 1'b1;
      for (int j = 0; j < i; j++) if (vals[j] == vals[i]) exp_dup = 1'b1;
    end
`endif
    if (pre >= DISP_SIZE)
      for (int d = 0; d < DISP_SIZE; d++)
        if (req[d]) begin
          v = q.pop_front();
          mapped[v] = 1'b1;
        end
    if (pre + vals.size() <= FL_SIZE)
      foreach (vals[i]) q.push_back(vals[i]);
  endtask

  // Compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("free_count", int'(fcount), q.size());
      chk("alloc_ready", int'(ready), (q.size() >= DISP_SIZE) ? 1 : 0);
      chk("dup_err", int'(dup_err), int'(exp_dup));
      if (q.size() >= DISP_SIZE) begin
        cmp_k = 0;
        for (int d = 0; d < DISP_SIZE; d++)
          if (req[d]) begin
            chk("alloc_rnid", int'(arnid[d]), q[cmp_k]);
            cmp_k++;
          end
      end
    end
  end

  task automatic idle();
    commit = 1'b0; vld = '0; dead = '0; all_dead = 1'b0; req = '0;
    for (int d = 0; d < DISP_SIZE; d++) begin
      old_r[d] = '0;
      rd_r[d]  = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cmt(input logic [DISP_SIZE-1:0] v, input logic [DISP_SIZE-1:0] dd,
                     input int o[DISP_SIZE], input int r[DISP_SIZE]);
    commit = 1'b1; vld = v; dead = dd;
    for (int d = 0; d < DISP_SIZE; d++) begin
      old_r[d] = RNID_W'(o[d]);
      rd_r[d]  = RNID_W'(r[d]);
      if (v[d]) mapped[(dd[d] ? r[d] : o[d])] = 1'b0;
    end
  endtask

  function automatic int pick();
    int s;
    s = $urandom_range(0, RNID_SIZE - 1);
    for (int i = 0; i < RNID_SIZE; i++) begin
      int j;
      j = (s + i) % RNID_SIZE;
      if (mapped[j]) begin
        mapped[j] = 1'b0;
        return j;
      end
    end
    return 0;
  endfunction

  initial begin
    int room;
    int v;
    idle();
    model_reset();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset image
    chk("rst_count", int'(fcount), 32);
    chk("rst_ready", int'(ready), 1);
    chk("rst_dup", int'(dup_err), 0);
    req = 4'b1111; #1;
    chk("first_rnid0", int'(arnid[0]), 32);
    chk("first_rnid1", int'(arnid[1]), 33);
    chk("first_rnid2", int'(arnid[2]), 34);
    chk("first_rnid3", int'(arnid[3]), 35);
    step();
    req = 4'b1111; #1;
    chk("second_count", int'(fcount), 28);
    chk("second_rnid0", int'(arnid[0]), 36);
    chk("second_rnid3", int'(arnid[3]), 39);
    step();
    req = 4'b1111;          // hands out 40..43 so 41 becomes a legal dead rd later
    step();
    idle();

    // Live frees from sparse slots 0 and 2
    cmt(4'b0101, 4'b0000, '{5, 0, 9, 0}, '{0, 0, 0, 0});
    step();
    idle(); #1;
    chk("sparse_push_count", int'(fcount), 22);

    // Slot 1 dead: returns its rd instead of old
    cmt(4'b0011, 4'b0010, '{3, 4, 0, 0}, '{40, 41, 0, 0});
    step();
    idle(); #1;
    chk("dead_push_count", int'(fcount), 24);

    // Drain to empty; the final group is the four freed rnids in push order
    for (int g = 0; g < 5; g++) begin
      req = 4'b1111;
      step();
    end
    req = 4'b1111; #1;
    chk("drain_rnid0", int'(arnid[0]), 5);
    chk("drain_rnid1", int'(arnid[1]), 9);
    chk("drain_rnid2", int'(arnid[2]), 3);
    chk("drain_rnid3", int'(arnid[3]), 41);
    step();
    idle(); #1;
    chk("empty_ready", int'(ready), 0);
    chk("empty_count", int'(fcount), 0);

    // Refill from empty: not poppable in the push cycle, ready the next one
    cmt(4'b1111, 4'b0000, '{0, 1, 2, 6}, '{0, 0, 0, 0}); #1;
    chk("refill_same_cycle_ready", int'(ready), 0);
    step();
    idle(); #1;
    chk("refill_next_ready", int'(ready), 1);
    chk("refill_next_count", int'(fcount), 4);
    req = 4'b1111; #1;
    chk("refill_rnid0", int'(arnid[0]), 0);
    chk("refill_rnid3", int'(arnid[3]), 6);
    step();
    idle();

    // Random legal traffic, wraps both pointers several times
    for (int c = 0; c < 100; c++) begin
      idle();
      if (q.size() >= DISP_SIZE && $urandom_range(0, 2) != 0) req = DISP_SIZE'($urandom_range(0, 15));
      room = FL_SIZE - q.size();
      if ($urandom_range(0, 3) != 0) begin
        commit = 1'b1;
        all_dead = ($urandom_range(0, 7) == 0);
        for (int d = 0; d < DISP_SIZE; d++) begin
          old_r[d] = RNID_W'($urandom_range(0, RNID_SIZE - 1));
          rd_r[d]  = RNID_W'($urandom_range(0, RNID_SIZE - 1));
          dead[d]  = 1'($urandom_range(0, 1));
          if (room > 0 && $urandom_range(0, 1) == 1) begin
            vld[d] = 1'b1;
            room--;
            v = pick();
            if (dead[d] || all_dead) rd_r[d] = RNID_W'(v);
            else old_r[d] = RNID_W'(v);
          end
        end
      end else begin
        vld = DISP_SIZE'($urandom_range(0, 15));   // no commit: must be ignored
        old_r[0] = RNID_W'($urandom_range(0, RNID_SIZE - 1));
      end
      step();
    end
    idle();

    // Double free: return an rnid still sitting in the list
    if (q.size() >= FL_SIZE) begin
      req = 4'b1111;
      step();
      idle();
    end
    v = q[0];
    commit = 1'b1; vld = 4'b0001; old_r[0] = RNID_W'(v);
    step();
    idle(); #1;
    chk("dup_err_set", int'(dup_err), DUP_EXP);
    step();
    chk("dup_err_sticky", int'(dup_err), DUP_EXP);

    // Asynchronous reset mid-operation
    chk_en = 1'b0;
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", int'(fcount), 32);
    chk("arst_ready", int'(ready), 1);
    chk("arst_dup", int'(dup_err), 0);
    chk("arst_rnid0", int'(arnid[0]), 32);
    chk("arst_rnid3", int'(arnid[3]), 35);
    req = '0;
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    req = 4'b1111;
    step();
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
